// File: rtl/div_seq_pkg.sv
// Shared types and constants for the iterative divide/remainder sequencer.
// Includes the state encoding, the datapath widths and the divide-op enum.
package div_seq_pkg;

    localparam int XLEN_DEF = 64;
    localparam int WORD_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // The decoder drives this in place of separate div/rem type flags.
    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_e;

    function automatic div_op_e to_div_op(input logic is_signed, input logic is_rem);
        div_op_e op;
        case ({is_rem, is_signed})
            2'b00:   op = OP_DIVU;
            2'b01:   op = OP_DIV;
            2'b10:   op = OP_REMU;
            default: op = OP_REM;
        endcase
        return op;
    endfunction

    function automatic logic op_is_rem(input div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quot} left and trial-subtract.
// The shifted remainder needs one extra bit when the divisor uses the MSB.
module div_step
    import div_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quot_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quot_o
);

    logic [XLEN:0] shifted;
    logic          ge;

    always_comb begin
        shifted = {rem_i, quot_i[XLEN-1]};
        ge      = (shifted >= {1'b0, divisor_i});
        // When ge holds the difference is below the divisor, so XLEN bits suffice.
        rem_o   = ge ? (shifted[XLEN-1:0] - divisor_i) : shifted[XLEN-1:0];
        quot_o  = {quot_i[XLEN-2:0], ge};
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU/REM/REMU (and W forms) sequencer around one restoring step.
// req_valid is held by the decoder until resp_valid; flush is the only abort.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            is_signed,
    input  logic            is_rem,
    input  logic            is_word,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic            stall,
    output div_state_e      dbg_state
);

    localparam int CNT_W = $clog2(XLEN);

    function automatic logic [XLEN-1:0] word_ext(input logic [WORD_W-1:0] x, input logic sgn);
        return {{(XLEN-WORD_W){sgn & x[WORD_W-1]}}, x};
    endfunction

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quot_q, quot_d;
    logic [XLEN-1:0]  dvsr_q, dvsr_d;
    div_op_e          op_q, op_d;
    logic             word_q, word_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]  resp_data_q, resp_data_d;

    logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_neg;
    logic            a_neg, b_neg, div_zero, ovf;
    logic [XLEN-1:0] rem_next, quot_next;
    logic [XLEN-1:0] q_fix, r_fix, sel, fin;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (dvsr_q),
        .rem_o     (rem_next),
        .quot_o    (quot_next)
    );

    // Operand conditioning at accept time.
    always_comb begin
        if (is_word) begin
            a_ext = word_ext(op1[WORD_W-1:0], is_signed);
            b_ext = word_ext(op2[WORD_W-1:0], is_signed);
        end else begin
            a_ext = op1;
            b_ext = op2;
        end
        a_neg = is_signed & a_ext[XLEN-1];
        b_neg = is_signed & b_ext[XLEN-1];
        a_abs = a_neg ? -a_ext : a_ext;
        b_abs = b_neg ? -b_ext : b_ext;

        min_neg = '0;
        if (is_word) begin
            min_neg[XLEN-1:WORD_W-1] = '1;
        end else begin
            min_neg[XLEN-1] = 1'b1;
        end
        div_zero = (b_ext == '0);
        ovf      = is_signed & (a_ext == min_neg) & (b_ext == '1);
    end

    // Result formation on the final iteration.
    always_comb begin
        q_fix = q_neg_q ? -quot_next : quot_next;
        r_fix = r_neg_q ? -rem_next : rem_next;
        sel   = op_is_rem(op_q) ? r_fix : q_fix;
        fin   = word_q ? word_ext(sel[WORD_W-1:0], 1'b1) : sel;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        quot_d       = quot_q;
        dvsr_d       = dvsr_q;
        op_d         = op_q;
        word_d       = word_q;
        q_neg_d      = q_neg_q;
        r_neg_d      = r_neg_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;

        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_d    = to_div_op(is_signed, is_rem);
                        word_d  = is_word;
                        q_neg_d = a_neg ^ b_neg;
                        r_neg_d = a_neg;
                        dvsr_d  = b_abs;
                        rem_d   = '0;
                        // W dividends start in the top half so 32 shifts consume them.
                        quot_d  = is_word ? (a_abs << WORD_W) : a_abs;
                        cnt_d   = is_word ? CNT_W'(WORD_W - 1) : CNT_W'(XLEN - 1);
                        if (div_zero) begin
                            resp_data_d  = is_rem ? (is_word ? word_ext(a_ext[WORD_W-1:0], 1'b1) : a_ext)
                                                  : '1;
                            resp_valid_d = 1'b1;
                            state_d      = ST_DONE;
                        end else if (ovf) begin
                            resp_data_d  = is_rem ? '0 : a_ext;
                            resp_valid_d = 1'b1;
                            state_d      = ST_DONE;
                        end else begin
                            state_d = ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    rem_d  = rem_next;
                    quot_d = quot_next;
                    if (cnt_q == '0) begin
                        resp_data_d  = fin;
                        resp_valid_d = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rem_q        <= '0;
            quot_q       <= '0;
            dvsr_q       <= '0;
            op_q         <= OP_DIV;
            word_q       <= 1'b0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            quot_q       <= quot_d;
            dvsr_q       <= dvsr_d;
            op_q         <= op_d;
            word_q       <= word_d;
            q_neg_q      <= q_neg_d;
            r_neg_q      <= r_neg_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign stall      = req_valid & ~resp_valid_q;
    assign dbg_state  = state_q;

    // A divide in progress may only be abandoned through flush.
    a_req_held: assert property (@(posedge clk) disable iff (!rst)
        ((state_q == ST_CALC) && !flush) |-> req_valid);

endmodule
